// File: rtl/pulse_decoder_pkg.sv
// pulse_decoder_pkg
//   Shared types and constants for the pulse_decoder_3to8 slice.
//   - state_t      : replay FSM state (IDLE, DRIVE, GAP)
//   - CODE_W_DEF   : default code width (3 -> 8 output lines)
//   - DEPTH_DEF    : default FIFO depth
//   - HOLD_DEF     : default cycles each one-hot pattern is held
//   - onehot()     : 1 << code, returned on a wide vector so callers of any
//                    supported code width (<= 8) can take the low bits.
package pulse_decoder_pkg;

  localparam int CODE_W_DEF = 3;
  localparam int DEPTH_DEF  = 4;
  localparam int HOLD_DEF   = 2;

  localparam int ONEHOT_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] code);
    logic [ONEHOT_MAX_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pulse_decoder_3to8_if.sv
// pulse_decoder_3to8_if
//   Code input channel of the pulse decoder.
//   Handshake: Y is meaningful while Valid is high; a code transfers on every
//   rising clk edge where Valid && Ready. Ready depends only on the decoder's
//   registered FIFO occupancy, never on Valid. A code offered while Ready is
//   low is not taken and is lost unless the source keeps offering it.
//   Signals:
//     Y     [CODE_W] encoded index, driven by master
//     Valid [1]      Y valid, driven by master
//     Ready [1]      decoder can accept, driven by slave
interface pulse_decoder_3to8_if #(
  parameter int CODE_W = 3
);
  logic [CODE_W-1:0] Y;
  logic              Valid;
  logic              Ready;

  modport master (output Y, output Valid, input Ready);
  modport slave  (input Y, input Valid, output Ready);
endinterface

// File: rtl/code_fifo.sv
// code_fifo
//   Small synchronous FIFO holding pending codes.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears pointers,
//                  occupancy and storage so head is never X)
//     push, din  : write din at the tail (caller guarantees !full)
//     pop        : drop the head entry (caller guarantees !empty)
//     head       : entry at the read pointer
//     count      : occupancy 0..DEPTH
//     full/empty : occupancy flags decoded from count
//   Simultaneous push and pop leaves count unchanged and advances both
//   pointers. DEPTH must be a power of two so pointers wrap naturally.
module code_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pulse_decoder_3to8.sv
// pulse_decoder_3to8
//   Sequential 3-to-8 decoder. Codes arrive over a valid/ready channel, are
//   queued in code_fifo and replayed in arrival order as a one-hot pattern on
//   O held for HOLD cycles, followed by a single all-zero gap cycle.
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset, synchronous release
//     bus       : code channel (Y, Valid in; Ready out), slave side
//     O         : registered one-hot output, zero when idle or in gap
//     Busy      : FSM in DRIVE/GAP or FIFO non-empty
//     Count     : FIFO occupancy
//     dbg_state : current replay FSM state
//     Overflow  : only with PULSE_DECODER_OVERFLOW_EN defined; sticky flag set
//                 on any edge with Valid && !Ready, cleared only by rst_n.
//                 Without the macro, dropped codes are silent.
module pulse_decoder_3to8
  import pulse_decoder_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pulse_decoder_3to8_if.slave      bus,
  output logic [(1<<CODE_W)-1:0]   O,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Count,
  output state_t                   dbg_state
`ifdef PULSE_DECODER_OVERFLOW_EN
  ,
  output logic                     Overflow
`endif
);

  localparam int OUT_W = 1 << CODE_W;
  localparam int HCW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_t                  state;
  logic [HCW-1:0]          hold_cnt;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CODE_W-1:0]       head;
  logic [ONEHOT_MAX_W-1:0] head_wide;
  logic [OUT_W-1:0]        head_oh;

  // Ready comes from registered occupancy only: a pop on the same edge does
  // not open a slot for a push when the FIFO is full.
  assign bus.Ready = !fifo_full;
  assign push      = bus.Valid && !fifo_full;

  // The head is consumed whenever the FSM is free to start a new pattern.
  assign pop = ((state == IDLE) || (state == GAP)) && !fifo_empty;

  always_comb begin
    head_wide = onehot(8'(head));
    head_oh   = head_wide[OUT_W-1:0];
  end

  code_fifo #(
    .W     (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.Y),
    .head  (head),
    .count (Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Replay FSM. hold_cnt counts remaining DRIVE cycles after the first, so a
  // pattern is visible for exactly HOLD cycles before GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      O        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            O        <= head_oh;
            hold_cnt <= HCW'(HOLD - 1);
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            O     <= '0;
            state <= GAP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        GAP: begin
          if (pop) begin
            O        <= head_oh;
            hold_cnt <= HCW'(HOLD - 1);
            state    <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          O     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

`ifdef PULSE_DECODER_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Overflow <= 1'b0;
    end else if (bus.Valid && fifo_full) begin
      Overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_decoder_3to8.sv
// tb_pulse_decoder_3to8
//   Drives pulse_decoder_3to8 (CODE_W=3, DEPTH=4, HOLD=2) with directed and
//   random codes and compares every cycle against a queue-based reference:
//   a queue of accepted codes plus a queue of upcoming O values.
module tb_pulse_decoder_3to8;
  import pulse_decoder_pkg::*;

  localparam int CODE_W = 3;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pulse_decoder_3to8_if #(.CODE_W(CODE_W)) bus ();

  logic [7:0] o;
  logic       busy;
  logic [2:0] count;
  state_t     dbg_state;
`ifdef PULSE_DECODER_OVERFLOW_EN
  logic       overflow;
`endif

  pulse_decoder_3to8 #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH),
    .HOLD   (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .O         (o),
    .Busy      (busy),
    .Count     (count),
    .dbg_state (dbg_state)
`ifdef PULSE_DECODER_OVERFLOW_EN
    ,
    .Overflow  (overflow)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_err;

  logic [CODE_W-1:0] exp_q[$];   // codes accepted, not yet replayed
  logic [7:0]        out_q[$];   // O values scheduled for coming edges
  logic [7:0]        m_o;
  logic              m_gap;
  logic              m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    out_q.delete();
    m_o   = 8'h00;
    m_gap = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference: a new pattern starts only when nothing
  // is scheduled; push/drop is judged on the occupancy before the edge.
  task automatic model_edge(input logic v, input logic [CODE_W-1:0] y);
    int         pre;
    logic [7:0] one;
    logic [CODE_W-1:0] c;
    pre = exp_q.size();
    one = 8'd1;
    if (out_q.size() > 0) begin
      m_o   = out_q.pop_front();
      m_gap = (m_o == 8'h00);
    end else if (pre > 0) begin
      c     = exp_q.pop_front();
      m_o   = one << c;
      m_gap = 1'b0;
      for (int i = 0; i < HOLD - 1; i++) out_q.push_back(m_o);
      out_q.push_back(8'h00);
    end else begin
      m_o   = 8'h00;
      m_gap = 1'b0;
    end
    if (v) begin
      if (pre < DEPTH) exp_q.push_back(y);
      else             m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    check_val("o",     32'(o),     32'(m_o));
    check_val("count", 32'(count), 32'(exp_q.size()));
    check_val("ready", 32'(bus.Ready), 32'(exp_q.size() != DEPTH));
    check_val("busy",  32'(busy),  32'((m_o != 8'h00) || m_gap || (exp_q.size() != 0)));
`ifdef PULSE_DECODER_OVERFLOW_EN
    check_val("overflow", 32'(overflow), 32'(m_ovf));
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a negedge; outputs are checked at the next negedge.
  task automatic step(input logic v, input logic [CODE_W-1:0] y);
    bus.Valid = v;
    bus.Y     = y;
    @(posedge clk);
    model_edge(v, y);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)));
  endtask

  logic [7:0] burst_exp [12];
  logic [7:0] burst_obs [14];
  int         bound;
  int         dens;

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    burst_exp = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00,
                  8'h08, 8'h08, 8'h00, 8'h20, 8'h20, 8'h00};

    // Reset held with a valid code offered: nothing may be stored.
    rst_n     = 1'b0;
    bus.Valid = 1'b1;
    bus.Y     = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_o",     32'(o),         32'h00);
      check_val("rst_ready", 32'(bus.Ready), 32'h1);
      check_val("rst_count", 32'(count),     32'h0);
      check_val("rst_busy",  32'(busy),      32'h0);
    end
    bus.Valid = 1'b0;
    rst_n     = 1'b1;
    idle(3);

    // Single code: one cycle latency, HOLD cycles, one gap, back to idle.
    step(1'b1, 3'd2);
    step(1'b0, 3'd0);
    check_val("single_o_k1", 32'(o), 32'h04);
    step(1'b0, 3'd0);
    check_val("single_o_k2", 32'(o), 32'h04);
    step(1'b0, 3'd0);
    check_val("single_o_k3", 32'(o), 32'h00);
    step(1'b0, 3'd0);
    check_val("single_busy", 32'(busy), 32'h0);

    // Burst 0,7,3,5 on consecutive edges.
    step(1'b1, 3'd0); burst_obs[0] = o;
    step(1'b1, 3'd7); burst_obs[1] = o;
    check_val("burst_ready", 32'(bus.Ready), 32'h1);
    step(1'b1, 3'd3); burst_obs[2] = o;
    step(1'b1, 3'd5); burst_obs[3] = o;
    for (int i = 4; i < 14; i++) begin
      step(1'b0, 3'd0);
      burst_obs[i] = o;
    end
    for (int i = 0; i < 12; i++) check_val($sformatf("burst_seq%0d", i), 32'(burst_obs[i+1]), 32'(burst_exp[i]));
    idle(2);

    // Overflow: start one pattern, then offer six codes back-to-back.
    step(1'b1, 3'd1);
    step(1'b0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'($urandom_range(0, 7)));
      if (i == 4) check_val("full_ready", 32'(bus.Ready), 32'h0);
    end
`ifdef PULSE_DECODER_OVERFLOW_EN
    check_val("ovf_set", 32'(overflow), 32'h1);
`endif
    idle(20);
`ifdef PULSE_DECODER_OVERFLOW_EN
    check_val("ovf_sticky", 32'(overflow), 32'h1);
`endif

    // Random traffic at varying densities (exercises push/pop at Count=2).
    for (int blk = 0; blk < 8; blk++) begin
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 60; i++) begin
        step(1'($urandom_range(0, 3) < dens), 3'($urandom_range(0, 7)));
      end
    end
    idle(20);

    // Async reset mid-DRIVE with codes still queued.
    step(1'b1, 3'd4);
    step(1'b1, 3'd1);
    step(1'b1, 3'd6);
    bound = 0;
    while (m_o != 8'h10 && bound < 20) begin
      step(1'b0, 3'd0);
      bound++;
    end
    check_val("mid_o_pre", 32'(o), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_o",     32'(o),     32'h00);
    check_val("async_count", 32'(count), 32'h0);
    check_val("async_busy",  32'(busy),  32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Whole-run watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
